det_arb_ctrl: RTL and testbench

- Round-robin scheduler that shares one 2-bit-symbol Moore pattern detector (`i_input`/`o_output` style, one symbol consumed per clock) between N requesters.
- Grants one requester a burst and forces the detector to a known state with a 2-symbol preamble. It then streams the burst, counts detector matches, and returns one result per burst.
- Sits between the requester streams and the detector instance.

---
 rtl/det_arb_pkg.sv | 29 ++
 rtl/det_arb_rr.sv | 52 +++++
 rtl/det_arb_ctrl.sv | 159 +++++++++++++++
 tb/tb_det_arb_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/det_arb_pkg.sv
// Shared definitions for the detector arbiter.
//   - FSM state encoding (localparams plus the enum built on them)
//   - default preamble / idle symbols used as parameter defaults by det_arb_ctrl
package det_arb_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PRE0   = 3'd1;
  localparam logic [2:0] PRE1   = 3'd2;
  localparam logic [2:0] XFER   = 3'd3;
  localparam logic [2:0] DRAIN0 = 3'd4;
  localparam logic [2:0] DRAIN1 = 3'd5;
  localparam logic [2:0] RESP   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = IDLE,
    S_PRE0   = PRE0,
    S_PRE1   = PRE1,
    S_XFER   = XFER,
    S_DRAIN0 = DRAIN0,
    S_DRAIN1 = DRAIN1,
    S_RESP   = RESP
  } state_t;

  // PRE0 followed by PRE1 parks the detector in a non-match state.
  localparam logic [1:0] DEF_PRE0     = 2'b00;
  localparam logic [1:0] DEF_PRE1     = 2'b10;
  localparam logic [1:0] DEF_IDLE_SYM = 2'b00;

endpackage

// File: rtl/det_arb_rr.sv
// N-way grant picker (purely combinational).
// Build option: DET_ARB_RR_EN
//   defined   -> round-robin: first set request at or after ptr wins
//   undefined -> fixed priority: lowest set index wins, no ptr port
// Ports:
//   req  in  N          request vector
//   ptr  in  $clog2(N)  registered round-robin start index (RR build only)
//   any  out 1          at least one request set
//   idx  out $clog2(N)  index of the winning request
module det_arb_rr
  import det_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
`ifdef DET_ARB_RR_EN
  input  logic [$clog2(N)-1:0] ptr,
`endif
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);

`ifdef DET_ARB_RR_EN
  int k;

  always_comb begin
    any = 1'b0;
    idx = '0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any = 1'b1;
        idx = $clog2(N)'(k);
      end
    end
  end
`else
  // Scanning downwards lets the lowest set index overwrite the others.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = $clog2(N)'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/det_arb_ctrl.sv
// Shares one 2-bit-symbol Moore pattern detector between N requesters.
// Each granted burst is preceded by a PRE0,PRE1 preamble so the detector
// starts from a known non-match state; matches on burst symbols are counted
// and one result is returned per burst.
// Build option: DET_ARB_RR_EN (round-robin when defined, fixed priority otherwise)
// Ports:
//   clk, rstn                       clock, async active-low reset
//   i_req_valid/i_req_sym/i_req_last per-requester symbol stream (sym k = [2k+1:2k])
//   o_req_ready                      accept strobe for the granted requester
//   o_det_sym / i_det_match          registered detector input / Moore output
//   o_rsp_valid/src/count/err        burst result, held until i_rsp_ready
//   o_busy                           high whenever the FSM is not IDLE
//
// state  | meaning
// IDLE   | waiting for a request, drives IDLE_SYM
// PRE0   | registers PRE0 to the detector
// PRE1   | registers PRE1 to the detector
// XFER   | streaming granted requester's symbols
// DRAIN0 | flushing tag pipe (stage 1)
// DRAIN1 | flushing tag pipe (stage 2)
// RESP   | result presented, waiting for i_rsp_ready
module det_arb_ctrl
  import det_arb_pkg::*;
#(
  parameter int         N        = 4,
  parameter int         CNT_W    = 8,
  parameter logic [1:0] PRE0     = DEF_PRE0,
  parameter logic [1:0] PRE1     = DEF_PRE1,
  parameter logic [1:0] IDLE_SYM = DEF_IDLE_SYM
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         i_req_valid,
  input  logic [2*N-1:0]       i_req_sym,
  input  logic [N-1:0]         i_req_last,
  output logic [N-1:0]         o_req_ready,
  output logic [1:0]           o_det_sym,
  input  logic                 i_det_match,
  output logic                 o_rsp_valid,
  output logic [$clog2(N)-1:0] o_rsp_src,
  output logic [CNT_W-1:0]     o_rsp_count,
  output logic                 o_rsp_err,
  input  logic                 i_rsp_ready,
  output logic                 o_busy
);

  localparam int               IDX_W   = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q;
  logic [1:0]         sym_q, sym_d;
  logic [1:0]         tag_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               push, err_set, grant_load, rsp_acc;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;

`ifdef DET_ARB_RR_EN
  logic [IDX_W-1:0]   ptr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else if (rsp_acc) begin
      ptr_q <= (grant_q == IDX_W'(N - 1)) ? '0 : grant_q + 1'b1;
    end
  end
`endif

  det_arb_rr #(.N(N)) u_rr (
    .req (i_req_valid),
`ifdef DET_ARB_RR_EN
    .ptr (ptr_q),
`endif
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    sym_d       = IDLE_SYM;
    push        = 1'b0;
    err_set     = 1'b0;
    grant_load  = 1'b0;
    rsp_acc     = 1'b0;
    o_req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_load = 1'b1;
          state_d    = S_PRE0;
        end
      end
      S_PRE0: begin
        sym_d   = PRE0;
        state_d = S_PRE1;
      end
      S_PRE1: begin
        sym_d   = PRE1;
        state_d = S_XFER;
      end
      S_XFER: begin
        o_req_ready[grant_q] = 1'b1;
        if (i_req_valid[grant_q]) begin
          sym_d = i_req_sym[{grant_q, 1'b0} +: 2];
          push  = 1'b1;
          if (i_req_last[grant_q]) state_d = S_DRAIN0;
        end else begin
          // Bubble aborts the burst; the idle symbol carries a zero tag.
          err_set = 1'b1;
          state_d = S_DRAIN0;
        end
      end
      S_DRAIN0: state_d = S_DRAIN1;
      S_DRAIN1: state_d = S_RESP;
      S_RESP: begin
        if (i_rsp_ready) begin
          rsp_acc = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tag_q[1] is the tag of the symbol whose match result is on i_det_match now.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      sym_q   <= IDLE_SYM;
      tag_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      tag_q   <= {tag_q[0], push};
      if (grant_load) grant_q <= pick_idx;
      if (grant_load || rsp_acc) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        if (tag_q[1] && i_det_match && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 1'b1;
        if (err_set) err_q <= 1'b1;
      end
    end
  end

  assign o_det_sym   = sym_q;
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_src   = grant_q;
  assign o_rsp_count = cnt_q;
  assign o_rsp_err   = err_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_det_arb_ctrl.sv
// Bench for det_arb_ctrl: per-requester symbol queues feed the DUT, a small
// Moore detector (matches symbols 00 and 01) closes the loop, and a monitor
// compares every accepted response against an expected-result queue.
module tb_det_arb_ctrl;
  localparam int N     = 4;
  localparam int CNT_W = 8;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   i_req_valid;
  logic [2*N-1:0] i_req_sym;
  logic [N-1:0]   i_req_last;
  logic [N-1:0]   o_req_ready;
  logic [1:0]     o_det_sym;
  logic           i_det_match;
  logic           o_rsp_valid;
  logic [1:0]     o_rsp_src;
  logic [CNT_W-1:0] o_rsp_count;
  logic           o_rsp_err;
  logic           i_rsp_ready;
  logic           o_busy;

  det_arb_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_req_valid (i_req_valid),
    .i_req_sym   (i_req_sym),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_det_sym   (o_det_sym),
    .i_det_match (i_det_match),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_src   (o_rsp_src),
    .o_rsp_count (o_rsp_count),
    .o_rsp_err   (o_rsp_err),
    .i_rsp_ready (i_rsp_ready),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  // Detector model: one-symbol Moore state, match when symbol MSB is 0.
  logic det_m;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) det_m <= 1'b0;
    else       det_m <= ~o_det_sym[1];
  end
  assign i_det_match = det_m;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int rise_cyc = 0;
  int n_rsp = 0;
  logic prev_valid = 1'b0;

  logic [2:0]  sbuf [N][512];
  int          head [N];
  int          tail [N];
  logic [10:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic push_sym(input int k, input logic [1:0] s, input logic last);
    sbuf[k][tail[k]] = {last, s};
    tail[k]++;
  endtask

  task automatic exp_rsp(input logic [1:0] src, input logic [7:0] cnt, input logic err);
    exp_q.push_back({src, cnt, err});
  endtask

  task automatic wait_rsp(input int target, input string name);
    int t;
    t = 0;
    while (n_rsp < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (n_rsp < target) begin
      errors++;
      $display("FAIL timeout_%s: responses=%0d expected %0d", name, n_rsp, target);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (head[k] < tail[k]) begin
        i_req_valid[k]       = 1'b1;
        i_req_sym[2*k +: 2]  = sbuf[k][head[k]][1:0];
        i_req_last[k]        = sbuf[k][head[k]][2];
      end else begin
        i_req_valid[k]       = 1'b0;
        i_req_sym[2*k +: 2]  = 2'b00;
        i_req_last[k]        = 1'b0;
      end
    end
  endtask

  // Requester driver: sample handshakes at the edge, update inputs 1 unit later.
  initial begin
    logic [N-1:0] acc;
    forever begin
      @(posedge clk);
      cyc++;
      acc = i_req_valid & o_req_ready;
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          if (sbuf[k][head[k]][2]) last_acc_cyc = cyc;
          head[k]++;
        end
      end
      drive();
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    logic [10:0] e;
    if (rstn && o_rsp_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rstn && o_rsp_valid;
    if (rstn && o_rsp_valid && i_rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got src=%0d count=%0d err=%0b, none expected",
                 o_rsp_src, o_rsp_count, o_rsp_err);
      end else begin
        e = exp_q.pop_front();
        check("rsp_src",   32'(o_rsp_src),   32'(e[10:9]));
        check("rsp_count", 32'(o_rsp_count), 32'(e[8:1]));
        check("rsp_err",   32'(o_rsp_err),   32'(e[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] prev;
    bit seen;
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    i_rsp_ready = 1'b1;
    drive();
    #2;
    check("reset_outputs",
          {o_req_ready, o_det_sym, o_rsp_valid, o_rsp_src, o_rsp_count, o_rsp_err, o_busy},
          32'd0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;

    // Basic burst from req0: 00,00,11,11,01,00 -> four matches.
    push_sym(0, 2'b00, 1'b0);
    push_sym(0, 2'b00, 1'b0);
    push_sym(0, 2'b11, 1'b0);
    push_sym(0, 2'b11, 1'b0);
    push_sym(0, 2'b01, 1'b0);
    push_sym(0, 2'b00, 1'b1);
    exp_rsp(2'd0, 8'd4, 1'b0);
    seen = 1'b0;
    prev = o_det_sym;
    for (int t = 0; t < 50 && !seen; t++) begin
      prev = o_det_sym;
      @(negedge clk);
      seen = o_req_ready[0];
    end
    check("grant0_seen", 32'(seen), 32'd1);
    check("preamble_pre1", 32'(o_det_sym), 32'(2'b10));
    check("preamble_pre0", 32'(prev), 32'(2'b00));
    wait_rsp(1, "basic");
    check("rsp_latency", 32'(rise_cyc - last_acc_cyc + 1), 32'd3);

    // Bubble after two symbols from req2, then a normal burst from req0.
    push_sym(2, 2'b00, 1'b0);
    push_sym(2, 2'b01, 1'b0);
    exp_rsp(2'd2, 8'd2, 1'b1);
    wait_rsp(2, "bubble");
    push_sym(0, 2'b01, 1'b0);
    push_sym(0, 2'b10, 1'b1);
    exp_rsp(2'd0, 8'd1, 1'b0);
    wait_rsp(3, "after_bubble");

    // 300 matching symbols: count saturates.
    for (int i = 0; i < 300; i++) push_sym(1, 2'b00, (i == 299));
    exp_rsp(2'd1, 8'd255, 1'b0);
    wait_rsp(4, "saturate");

    // Response stall: held fields, no new grant while req1 waits.
    @(posedge clk);
    #1 i_rsp_ready = 1'b0;
    push_sym(3, 2'b01, 1'b0);
    push_sym(3, 2'b01, 1'b0);
    push_sym(3, 2'b10, 1'b1);
    exp_rsp(2'd3, 8'd2, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = o_rsp_valid;
    end
    check("stall_rsp_seen", 32'(seen), 32'd1);
    push_sym(1, 2'b11, 1'b1);
    exp_rsp(2'd1, 8'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold",
            {o_rsp_valid, o_busy, o_req_ready, o_rsp_src, o_rsp_count, o_rsp_err},
            {15'd0, 1'b1, 1'b1, 4'b0000, 2'd3, 8'd2, 1'b0});
    end
    @(posedge clk);
    #1 i_rsp_ready = 1'b1;
    wait_rsp(6, "stall");

    // Async reset in the middle of a req2 burst: no response may follow.
    for (int i = 0; i < 8; i++) push_sym(2, 2'b01, (i == 7));
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = o_req_ready[2];
    end
    check("grant2_seen", 32'(seen), 32'd1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_outputs",
          {o_req_ready, o_det_sym, o_rsp_valid, o_rsp_src, o_rsp_count, o_rsp_err, o_busy},
          32'd0);
    for (int k = 0; k < N; k++) head[k] = tail[k];
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after_reset", {o_busy, o_rsp_valid}, 32'd0);

    // req1 and req3 together from pointer 0; req0 re-requests during req1.
    push_sym(1, 2'b00, 1'b0);
    push_sym(1, 2'b01, 1'b1);
    push_sym(3, 2'b11, 1'b0);
    push_sym(3, 2'b00, 1'b1);
    exp_rsp(2'd1, 8'd2, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = o_req_ready[1];
    end
    check("grant1_first", 32'(seen), 32'd1);
    push_sym(0, 2'b01, 1'b1);
`ifdef DET_ARB_RR_EN
    exp_rsp(2'd3, 8'd1, 1'b0);
    exp_rsp(2'd0, 8'd1, 1'b0);
`else
    exp_rsp(2'd0, 8'd1, 1'b0);
    exp_rsp(2'd3, 8'd1, 1'b0);
`endif
    wait_rsp(9, "arbitration");

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
